bet_trit_serializer: RTL

Transmit side of the BET (binary-encoded ternary) trit-strobe interface. Each trit is 2 bits: 01 = 0, 11 = 1, 10 = 2, and 00 is invalid and read as 11. The block accepts a parallel word of N trits through a valid/ready handshake. It serialises the word one trit at a time on a 2-bit data bus, with a binary enable strobe, so that a downstream ternary D-latch (data on its Data input, strobe on its Enable) captures each trit with full setup and hold margin.

---
 rtl/bet_pkg.sv | 56 +++++
 rtl/bet_mod3_acc.sv | 31 +++
 rtl/bet_trit_serializer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bet_pkg.sv
// bet_pkg: shared definitions for the BET (binary-encoded ternary) interface.
//
// Encoding of one trit in two bits:
//   01 = 0, 11 = 1, 10 = 2, 00 = invalid (read as 1 / 11).
//
// Contents:
//   trit_t                 - two-bit BET trit
//   BET_0/BET_1/BET_2/BET_INV
//   bet_norm(t)            - maps 00 to 11, all other codes unchanged
//   bet_dec(t)             - trit to value 0..2 (invalid reads as 1)
//   bet_enc(v)             - value 0..2 to trit
//   bet_add3(a, b)         - (a + b) mod 3 on values 0..2
//   bet_state_e            - serializer FSM states
package bet_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t BET_0   = 2'b01;
    localparam trit_t BET_1   = 2'b11;
    localparam trit_t BET_2   = 2'b10;
    localparam trit_t BET_INV = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bet_state_e;

    function automatic trit_t bet_norm(input trit_t t);
        return (t == BET_INV) ? BET_1 : t;
    endfunction

    function automatic logic [1:0] bet_dec(input trit_t t);
        case (t)
            BET_0:   return 2'd0;
            BET_2:   return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic trit_t bet_enc(input logic [1:0] v);
        case (v)
            2'd0:    return BET_0;
            2'd1:    return BET_1;
            default: return BET_2;
        endcase
    endfunction

    function automatic logic [1:0] bet_add3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/bet_mod3_acc.sv
// bet_mod3_acc: combinational mod-3 sum of a word of BET trits.
//
// Each trit is normalised and decoded (01->0, 11->1, 10->2), the values are
// summed modulo 3 and the result is re-encoded as a BET trit. Used by the
// transmit serializer for its check trit and intended for the receive-side
// checker as well, which is why it normalises its own input.
//
// Ports:
//   word_i  in   2*N_TRITS  trit k in bits [2k+1:2k]
//   sum_o   out  2          BET-encoded mod-3 sum
module bet_mod3_acc
    import bet_pkg::*;
#(
    parameter int N_TRITS = 4
) (
    input  logic [2*N_TRITS-1:0] word_i,
    output logic [1:0]           sum_o
);

    logic [1:0] acc;

    always_comb begin
        acc = 2'd0;
        for (int k = 0; k < N_TRITS; k++) begin
            acc = bet_add3(acc, bet_dec(bet_norm(word_i[2*k +: 2])));
        end
    end

    assign sum_o = bet_enc(acc);

endmodule

// File: rtl/bet_trit_serializer.sv
// bet_trit_serializer: transmit side of the BET trit-strobe interface.
//
// Accepts a word of N_TRITS BET trits over a valid/ready handshake and sends
// it one trit per three-cycle slot (SETUP, STROBE, HOLD) so that a ternary
// D-latch sees stable data for one cycle before and after its enable pulse.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only while idle; in_word is sampled only on that edge.
//
// Optional feature (macro BET_SER_CHECK_EN): when defined, one extra slot
// carrying the mod-3 sum of the data trits is sent after the data trits and
// out_last marks that slot. When undefined no check logic is built.
//
// Ports:
//   clk          in   1          clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   in_valid     in   1          in_word is valid
//   in_ready     out  1          block can accept a word (idle)
//   in_word      in   2*N_TRITS  trit k in bits [2k+1:2k], trit 0 sent first
//   out_trit     out  2          BET trit to the latch Data input
//   out_en       out  1          latch Enable strobe
//   out_last     out  1          high during the final slot of a word
//   busy         out  1          high whenever not idle
//   dbg_state_o  out  2          current FSM state (bet_state_e) for debug
module bet_trit_serializer
    import bet_pkg::*;
#(
    parameter int N_TRITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N_TRITS-1:0] in_word,
    output logic [1:0]           out_trit,
    output logic                 out_en,
    output logic                 out_last,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

`ifdef BET_SER_CHECK_EN
    localparam int N_SLOTS = N_TRITS + 1;
`else
    localparam int N_SLOTS = N_TRITS;
`endif
    localparam int CW = ($clog2(N_TRITS + 1) < 1) ? 1 : $clog2(N_TRITS + 1);
    localparam int SW = 2 * N_SLOTS;
    localparam logic [CW-1:0] LAST_SLOT = CW'(N_SLOTS - 1);

    bet_state_e    state_q, state_d;
    logic [CW-1:0] slot_q, slot_d;
    // Low two bits always hold the trit of the current slot.
    logic [SW-1:0] shift_q, shift_d;

    logic [1:0]    out_trit_q, out_trit_d;
    logic          out_en_q, out_en_d;
    logic          out_last_q, out_last_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic [2*N_TRITS-1:0] norm_word;
    logic [SW-1:0]        load_word;

    always_comb begin
        norm_word = '0;
        for (int k = 0; k < N_TRITS; k++) begin
            norm_word[2*k +: 2] = bet_norm(in_word[2*k +: 2]);
        end
    end

`ifdef BET_SER_CHECK_EN
    logic [1:0] check_trit;

    bet_mod3_acc #(
        .N_TRITS (N_TRITS)
    ) u_mod3_acc (
        .word_i (norm_word),
        .sum_o  (check_trit)
    );

    // The check trit rides as one more slot above the data trits.
    assign load_word = {check_trit, norm_word};
`else
    assign load_word = norm_word;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SETUP;
                    slot_d  = '0;
                    shift_d = load_word;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = IDLE;
                end else begin
                    state_d = SETUP;
                    slot_d  = slot_q + CW'(1);
                    shift_d = shift_q >> 2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: decode them from the state being entered so
    // each registered value lines up with the cycle of that state.
    always_comb begin
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        out_en_d   = (state_d == STROBE);
        out_last_d = (state_d != IDLE) && (slot_d == LAST_SLOT);
        out_trit_d = (state_d == IDLE) ? BET_1 : shift_d[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            shift_q    <= '0;
            out_trit_q <= BET_1;
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            out_trit_q <= out_trit_d;
            out_en_q   <= out_en_d;
            out_last_q <= out_last_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign out_trit    = out_trit_q;
    assign out_en      = out_en_q;
    assign out_last    = out_last_q;
    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
